// File: rtl/pronoc_pkg.sv
// Shared router configuration: VC count, buffer depth, message classes and the
// class-to-OVC permission table. Used by the OVC allocation tracker and its helpers.
package pronoc_pkg;

    localparam int V   = 4;
    localparam int B   = 4;
    localparam int C   = 2;
    localparam int Cw  = (C > 1) ? $clog2(C) : 1;
    localparam int CVw = C * V;
    localparam logic [CVw-1:0] CLASS_SETTING = '1;

    // Counter must hold the full range 0..B inclusive.
    function automatic int cred_width(input int depth);
        return (depth > 0) ? $clog2(depth + 1) : 1;
    endfunction

    localparam int CRW = cred_width(B);

endpackage

// File: rtl/ovc_credit_counter.sv
// Per-OVC downstream credit counter, saturating at 0 and B.
// ovf/udf are single-cycle event flags; the parent decides whether to keep them.
module ovc_credit_counter
    import pronoc_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic dec,
    input  logic inc,
    output logic has_cred,
    output logic ovf,
    output logic udf
);

    localparam logic [CRW-1:0] FULL = CRW'(B);

    logic [CRW-1:0] cnt;
    logic [CRW-1:0] cnt_nxt;

    // A simultaneous send and return cancel out, so neither edge can fault.
    always_comb begin
        cnt_nxt = cnt;
        ovf     = 1'b0;
        udf     = 1'b0;
        if (inc && !dec) begin
            if (cnt == FULL) ovf = 1'b1;
            else             cnt_nxt = cnt + 1'b1;
        end else if (dec && !inc) begin
            if (cnt == '0) udf = 1'b1;
            else           cnt_nxt = cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= FULL;
            has_cred <= (B > 0);
        end else begin
            cnt      <= cnt_nxt;
            has_cred <= (cnt_nxt != '0);
        end
    end

endmodule

// File: rtl/ovc_list.sv
// Class permission lookup: returns the OVCs a message class may use.
// Out-of-range classes get an empty mask so they can never be granted.
module ovc_list
    import pronoc_pkg::*;
#(
    parameter logic [CVw-1:0] SET = CLASS_SETTING
) (
    input  logic [Cw-1:0] class_in,
    output logic [V-1:0]  ovcs_out
);

    always_comb begin
        ovcs_out = '0;
        if (C <= 1) begin
            ovcs_out = '1;
        end else if (int'(class_in) < C) begin
            ovcs_out = SET[int'(class_in)*V +: V];
        end
    end

endmodule

// File: rtl/ovc_alloc_tracker.sv
// Output-VC allocator and state holder for one output port: class masking,
// priority preference, round-robin grant, busy and credit tracking.
// Optional macro OVC_ALLOC_ERR_CHK_EN enables sticky error flags and sim assertions.
module ovc_alloc_tracker
    import pronoc_pkg::*;
#(
    parameter logic [CVw-1:0] CLASS_CFG = CLASS_SETTING
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    input  logic [Cw-1:0] req_class,
    input  logic [V-1:0]  req_vc_pri,
    output logic          grant_valid,
    output logic [V-1:0]  grant_ovc,
    input  logic [V-1:0]  flit_sent,
    input  logic          tail_sent,
    input  logic [V-1:0]  credit_in,
    output logic [V-1:0]  ovc_free,
    output logic [V-1:0]  ovc_has_cred,
    output logic          err_overflow,
    output logic          err_underflow
);

    localparam int RW = (V > 1) ? $clog2(V) : 1;

    logic [V-1:0]  cm;
    logic [V-1:0]  cand;
    logic [V-1:0]  pref;
    logic [V-1:0]  pick;
    logic [RW-1:0] rr;
    logic [RW-1:0] gidx;
    logic          found;
    logic [V-1:0]  ovf_vec;
    logic [V-1:0]  udf_vec;

    ovc_list #(.SET(CLASS_CFG)) u_list (
        .class_in (req_class),
        .ovcs_out (cm)
    );

    for (genvar v = 0; v < V; v++) begin : g_cred
        ovc_credit_counter u_cc (
            .clk      (clk),
            .reset    (reset),
            .dec      (flit_sent[v]),
            .inc      (credit_in[v]),
            .has_cred (ovc_has_cred[v]),
            .ovf      (ovf_vec[v]),
            .udf      (udf_vec[v])
        );
    end

    assign cand = cm & ovc_free & ovc_has_cred;
    assign pref = cand & req_vc_pri;
    assign pick = (pref != '0) ? pref : cand;

    // Handshake: req_valid is an offer for this cycle only; grant_valid answers in the
    // same cycle. There is no ready/stall -- an unanswered requester simply retries.
    always_comb begin
        grant_ovc = '0;
        gidx      = '0;
        found     = 1'b0;
        for (int i = 0; i < V; i++) begin
            if (!found && pick[(int'(rr) + i) % V]) begin
                found     = 1'b1;
                gidx      = RW'((int'(rr) + i) % V);
                grant_ovc[(int'(rr) + i) % V] = req_valid;
            end
        end
        grant_valid = req_valid & found;
    end

    // Release and a grant of a different OVC may land in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovc_free <= '1;
            rr       <= '0;
        end else begin
            ovc_free <= (ovc_free & ~grant_ovc) | (flit_sent & {V{tail_sent}});
            if (grant_valid) rr <= RW'((int'(gidx) + 1) % V);
        end
    end

`ifdef OVC_ALLOC_ERR_CHK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            err_overflow  <= err_overflow | (|ovf_vec);
            err_underflow <= err_underflow | (|udf_vec) | (|(flit_sent & ovc_free));
        end
    end

    a_flit_onehot:  assert property (@(posedge clk) disable iff (reset) $onehot0(flit_sent));
    a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(grant_ovc));
`else
    assign err_overflow  = 1'b0;
    assign err_underflow = 1'b0;
    logic unused_err;
    assign unused_err = ^{ovf_vec, udf_vec};
`endif

endmodule

// File: tb/tb_ovc_alloc_tracker.sv
// Self-checking bench for ovc_alloc_tracker (V=4, B=4, C=2, class table 1100_0011).
// Honours OVC_ALLOC_ERR_CHK_EN for the expected error-flag values.
module tb_ovc_alloc_tracker;

    localparam logic [7:0] CLS_TAB = 8'b1100_0011;
    localparam int         NV = 4;
    localparam int         NB = 4;
`ifdef OVC_ALLOC_ERR_CHK_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_class;
    logic [3:0] req_vc_pri;
    logic       grant_valid;
    logic [3:0] grant_ovc;
    logic [3:0] flit_sent;
    logic       tail_sent;
    logic [3:0] credit_in;
    logic [3:0] ovc_free;
    logic [3:0] ovc_has_cred;
    logic       err_overflow;
    logic       err_underflow;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    ovc_alloc_tracker #(.CLASS_CFG(CLS_TAB)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_class     (req_class),
        .req_vc_pri    (req_vc_pri),
        .grant_valid   (grant_valid),
        .grant_ovc     (grant_ovc),
        .flit_sent     (flit_sent),
        .tail_sent     (tail_sent),
        .credit_in     (credit_in),
        .ovc_free      (ovc_free),
        .ovc_has_cred  (ovc_has_cred),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    // ---------------- behavioural model ----------------
    int cred_m [NV];
    bit busy_m [NV];
    int rr_m;
    bit eo_m, eu_m;

    function automatic logic [3:0] model_grant(input logic rv, input logic cls, input logic [3:0] pri);
        logic [7:0] tab;
        logic [3:0] cm, cand, pick, g;
        tab  = CLS_TAB;
        cm   = tab[int'(cls)*4 +: 4];
        cand = '0;
        for (int v = 0; v < NV; v++) cand[v] = cm[v] && !busy_m[v] && (cred_m[v] > 0);
        pick = ((cand & pri) != 0) ? (cand & pri) : cand;
        g = '0;
        if (rv) begin
            for (int i = 0; i < NV; i++) begin
                if (g == 0 && pick[(rr_m + i) % NV]) g[(rr_m + i) % NV] = 1'b1;
            end
        end
        return g;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < NV; v++) begin
                cred_m[v] = NB;
                busy_m[v] = 1'b0;
            end
            rr_m = 0;
            eo_m = 1'b0;
            eu_m = 1'b0;
        end else begin
            logic [3:0] g;
            g = model_grant(req_valid, req_class, req_vc_pri);
            for (int v = 0; v < NV; v++) begin
                if (flit_sent[v] && !busy_m[v]) eu_m = 1'b1;
                if (flit_sent[v] && !credit_in[v]) begin
                    if (cred_m[v] == 0) eu_m = 1'b1;
                    else                cred_m[v]--;
                end else if (credit_in[v] && !flit_sent[v]) begin
                    if (cred_m[v] == NB) eo_m = 1'b1;
                    else                 cred_m[v]++;
                end
                if (flit_sent[v] && tail_sent) busy_m[v] = 1'b0;
                if (g[v]) begin
                    busy_m[v] = 1'b1;
                    rr_m = (v + 1) % NV;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every non-reset cycle: compare all outputs with the model.
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            logic [3:0] g, fr, hc;
            g = model_grant(req_valid, req_class, req_vc_pri);
            for (int v = 0; v < NV; v++) begin
                fr[v] = !busy_m[v];
                hc[v] = cred_m[v] > 0;
            end
            check("m_grant_valid", {31'b0, grant_valid}, {31'b0, g != 0});
            check("m_grant_ovc", {28'b0, grant_ovc}, {28'b0, g});
            check("m_ovc_free", {28'b0, ovc_free}, {28'b0, fr});
            check("m_has_cred", {28'b0, ovc_has_cred}, {28'b0, hc});
            check("m_err_ovf", {31'b0, err_overflow}, {31'b0, ERR_ON & eo_m});
            check("m_err_udf", {31'b0, err_underflow}, {31'b0, ERR_ON & eu_m});
        end
    end

    // ---------------- driver ----------------
    task automatic cyc(input logic rv, input logic cls, input logic [3:0] pri,
                       input logic [3:0] fs, input logic ts, input logic [3:0] ci);
        @(posedge clk);
        #1;
        req_valid  = rv;
        req_class  = cls;
        req_vc_pri = pri;
        flit_sent  = fs;
        tail_sent  = ts;
        credit_in  = ci;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 4'b0, 4'b0, 1'b0, 4'b0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_free"}, {28'b0, ovc_free}, 32'hF);
        check({tag, "_cred"}, {28'b0, ovc_has_cred}, 32'hF);
        check({tag, "_gv"}, {31'b0, grant_valid}, 32'h0);
        check({tag, "_ovf"}, {31'b0, err_overflow}, 32'h0);
        check({tag, "_udf"}, {31'b0, err_underflow}, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_class = 1'b0; req_vc_pri = '0;
        flit_sent = '0; tail_sent = 1'b0; credit_in = '0;
        @(negedge clk);
        check_reset_state("rst");
        @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;

        // T1: class 0, preferred OVC1 granted; busy next cycle
        cyc(1'b1, 1'b0, 4'b0010, 4'b0, 1'b0, 4'b0);
        check("t1_grant", {28'b0, grant_ovc}, 32'h2);
        idle();
        check("t1_free", {28'b0, ovc_free}, 32'hD);

        // T2: class 1 ignores priority outside its mask
        cyc(1'b1, 1'b1, 4'b0001, 4'b0, 1'b0, 4'b0);
        check("t2_grant", {28'b0, grant_ovc}, 32'h4);

        // T3: drain OVC0 credits, it becomes ungrantable until a credit returns
        cyc(1'b1, 1'b0, 4'b0001, 4'b0, 1'b0, 4'b0);
        check("t3_grant0", {28'b0, grant_ovc}, 32'h1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 4'b0, 4'b0001, 1'b0, 4'b0);
        cyc(1'b0, 1'b0, 4'b0, 4'b0001, 1'b1, 4'b0);
        cyc(1'b1, 1'b0, 4'b0001, 4'b0, 1'b0, 4'b0);
        check("t3_nogrant", {31'b0, grant_valid}, 32'h0);
        check("t3_cred", {28'b0, ovc_has_cred}, 32'hE);
        cyc(1'b1, 1'b0, 4'b0001, 4'b0, 1'b0, 4'b0001);
        check("t3_same_cyc_cred", {31'b0, grant_valid}, 32'h0);
        cyc(1'b1, 1'b0, 4'b0001, 4'b0, 1'b0, 4'b0);
        check("t3_regrant", {28'b0, grant_ovc}, 32'h1);

        // T4: send+return on OVC2 at credit 1 leaves it at 1
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 4'b0, 4'b0100, 1'b0, 4'b0);
        cyc(1'b0, 1'b0, 4'b0, 4'b0100, 1'b0, 4'b0100);
        cyc(1'b0, 1'b0, 4'b0, 4'b0100, 1'b1, 4'b0);
        idle();
        check("t4_cred", {28'b0, ovc_has_cred}, 32'hB);
        check("t4_free", {28'b0, ovc_free}, 32'hC);
        check("t4_udf", {31'b0, err_underflow}, 32'h0);

        // T5: release of OVC1 is not grantable in the same cycle
        cyc(1'b1, 1'b0, 4'b0010, 4'b0010, 1'b1, 4'b0);
        check("t5_nogrant", {31'b0, grant_valid}, 32'h0);
        cyc(1'b1, 1'b0, 4'b0010, 4'b0, 1'b0, 4'b0);
        check("t5_grant", {28'b0, grant_ovc}, 32'h2);

        // T6: overflow on full OVC3, then flit on free OVC3
        cyc(1'b0, 1'b0, 4'b0, 4'b0, 1'b0, 4'b1000);
        idle();
        check("t6_ovf", {31'b0, err_overflow}, {31'b0, ERR_ON});
        check("t6_cred", {28'b0, ovc_has_cred}, 32'hB);
        cyc(1'b0, 1'b0, 4'b0, 4'b1000, 1'b0, 4'b0);
        idle();
        check("t6_udf", {31'b0, err_underflow}, {31'b0, ERR_ON});
        check("t6_ovf_sticky", {31'b0, err_overflow}, {31'b0, ERR_ON});

        // Mid-run reset restores everything at once
        @(posedge clk);
        #1;
        reset = 1'b1;
        req_valid = 1'b0; flit_sent = '0; tail_sent = 1'b0; credit_in = '0;
        @(negedge clk);
        check_reset_state("midrst");
        @(posedge clk);
        #1;
        reset = 1'b0;

        cyc(1'b1, 1'b1, 4'b1000, 4'b0, 1'b0, 4'b0);
        check("post_rst_grant", {28'b0, grant_ovc}, 32'h8);
        idle();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
